// File: rtl/alu_result_queue.sv
// ALU result selector feeding a 2-entry valid/ready queue with zero/neg/err flags.
// Latency 1 cycle from accept to head; in_ready drops only when both entries are held.
module alu_result_queue #(
  parameter int WIDTH     = 8,
  parameter int NUM_SRC   = 16,
  parameter int SEL_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               count,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned NSRC_U = NUM_SRC;

  state_t      state, state_nxt;
  entry_t      head, tail, new_entry;
  logic        accept, pop;
  logic        in_range;
  int unsigned sel_idx;
  logic [WIDTH-1:0] chan_val;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Channel mux; out-of-range selects never reach the loop match.
  assign sel_idx  = 32'(sel);
  assign in_range = sel_idx < NSRC_U;

  always_comb begin
    chan_val = '0;
    for (int unsigned k = 0; k < NSRC_U; k++) begin
      if (sel_idx == k) chan_val = src_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    new_entry = '0;
    if (!enable) begin
      new_entry.data = load_data;
    end else if (in_range) begin
      new_entry.data = chan_val;
    end else begin
      new_entry.err = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !pop)      state_nxt = FULL;
        else if (!accept && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    count     = state;
    in_ready  = (state != FULL) && !reset;
    out_valid = (state != EMPTY);
    out_data  = '0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    out_err   = 1'b0;
    if (out_valid) begin
      out_data = head.data;
      out_zero = (head.data == '0);
      out_neg  = head.data[WIDTH-1];
      out_err  = head.err;
    end
  end

  // Entry storage: head is always the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) head <= new_entry;
        ONE: begin
          if (accept && pop)  head <= new_entry;
          else if (accept)    tail <= new_entry;
        end
        FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (accept && new_entry.err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue (NUM_SRC=12, ERR_CNT_W=2 to reach err and saturation cases).
module tb_alu_result_queue;
  localparam int W  = 8;
  localparam int N  = 12;
  localparam int SW = 4;
  localparam int EW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] src_data;
  logic [SW-1:0]  sel;
  logic           enable;
  logic [W-1:0]   load_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_zero;
  logic           out_neg;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     count;
  logic [EW-1:0]  err_cnt;

  alu_result_queue #(.WIDTH(W), .NUM_SRC(N), .SEL_W(SW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .sel(sel), .enable(enable),
    .load_data(load_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [W:0] sbq[$];      // {err, data}, head at index 0
  int         m_err = 0;
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check outputs against the model at negedge, then advance the model on the edge.
  task automatic step();
    logic       acc, pop;
    logic [W:0] e, h;
    @(negedge clk);
    chk("count", 32'(count), sbq.size());
    chk("in_ready", 32'(in_ready), 32'(!reset && sbq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    chk("err_cnt", 32'(err_cnt), m_err);
    h = (sbq.size() != 0) ? sbq[0] : '0;
    chk("out_data", 32'(out_data), 32'(h[W-1:0]));
    chk("out_err", 32'(out_err), 32'(h[W]));
    chk("out_zero", 32'(out_zero), 32'(sbq.size() != 0 && h[W-1:0] == 0));
    chk("out_neg", 32'(out_neg), 32'(h[W-1]));
    acc = in_valid && !reset && sbq.size() < 2;
    pop = out_ready && !reset && sbq.size() != 0;
    if (!enable)     e = {1'b0, load_data};
    else if (sel < N) e = {1'b0, src_data[sel*W +: W]};
    else             e = {1'b1, {W{1'b0}}};
    @(posedge clk);
    last_acc = acc;
    if (reset) begin
      sbq.delete();
      m_err = 0;
    end else begin
      if (pop) void'(sbq.pop_front());
      if (acc) begin
        sbq.push_back(e);
        if (e[W] && m_err < (1 << EW) - 1) m_err++;
      end
    end
    #1;
  endtask

  initial begin
    logic done;
    reset = 1'b1; src_data = '0; sel = '0; enable = 1'b0; load_data = '0;
    in_valid = 1'b0; out_ready = 1'b0; last_acc = 1'b0;
    @(posedge clk); #1;
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    reset = 1'b0;

    // Single ADD result on channel 0
    enable = 1'b1; sel = 4'd0; src_data = {$urandom, $urandom, $urandom};
    src_data[7:0] = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_data", 32'(out_data), 32'h3C);
    step(); step();

    // Load path, sel ignored
    enable = 1'b0; sel = 4'hF; load_data = 8'h00; in_valid = 1'b1;
    step();
    chk("load_zero", 32'(out_zero), 1);
    load_data = 8'h80;
    step();
    chk("load_neg", 32'(out_neg), 1);
    in_valid = 1'b0;
    step();

    // Random in-range channels, including the top channel
    enable = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = SW'($urandom_range(0, N - 1));
      src_data = {$urandom, $urandom, $urandom};
      step();
    end
    sel = 4'd11; src_data = {$urandom, $urandom, $urandom};
    step();
    in_valid = 1'b0;
    step();

    // Out-of-range selects and counter saturation
    sel = 4'd13; in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    chk("err_cnt_3", 32'(err_cnt), 3);
    sel = 4'd12; in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    step();
    chk("err_cnt_sat", 32'(err_cnt), 3);

    // Back-pressure: A, B fill the queue, C must wait
    out_ready = 1'b0; enable = 1'b0; in_valid = 1'b1;
    load_data = 8'h11; step();
    load_data = 8'h22; step();
    load_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      src_data = {$urandom, $urandom, $urandom};
      sel = SW'($urandom);
      step();
    end
    chk("bp_full", 32'(count), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    sel = 4'hF;
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (last_acc) done = 1'b1;
    end
    chk("bp_c_accepted", 32'(done), 1);
    in_valid = 1'b0;
    repeat (4) step();

    // Streaming with one entry resident
    out_ready = 1'b0; load_data = 8'hA5; in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      load_data = W'(i);
      step();
      chk("stream_count", 32'(count), 1);
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Reset while full with in_valid held
    out_ready = 1'b0; enable = 1'b1; sel = 4'd13; in_valid = 1'b1;
    repeat (2) step();
    chk("pre_rst_full", 32'(count), 2);
    reset = 1'b1; enable = 1'b0; load_data = 8'h5A;
    step();
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_err_cnt", 32'(err_cnt), 0);
    reset = 1'b0; in_valid = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
